// File: rtl/nd_array_split_buffer.sv
// Splits one ROWS x COLS frame into a lo slice (rows 0..SPLIT-1) and a hi slice
// (remaining rows, optionally reversed) on two independently drained output registers.
module nd_array_split_buffer #(
  parameter int WIDTH      = 8,
  parameter int COLS       = 16,
  parameter int ROWS       = 12,
  parameter int SPLIT      = 4,
  parameter int REVERSE_HI = 0,
  parameter int TAGW       = 3
) (
  input  logic                                CLK,
  input  logic                                ASYNCRESET_N,
  input  logic [ROWS*COLS*WIDTH-1:0]          I0,
  input  logic                                I1__0,
  input  logic [TAGW-1:0]                     I1__1,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [SPLIT*COLS*WIDTH-1:0]         O0,
  output logic                                O0_valid,
  input  logic                                O0_ready,
  output logic [(ROWS-SPLIT)*COLS*WIDTH-1:0]  O1,
  output logic [TAGW-1:0]                     O2__0,
  output logic                                O2__1,
  output logic                                O1_valid,
  input  logic                                O1_ready,
  output logic [15:0]                         frame_count
);

  localparam int ROW_W   = COLS*WIDTH;
  localparam int HI_ROWS = ROWS-SPLIT;

  logic [SPLIT*ROW_W-1:0]   lo_d, lo_q;
  logic [HI_ROWS*ROW_W-1:0] hi_d, hi_q;
  logic [TAGW-1:0]          tag_q;
  logic                     flag_q;
  logic                     lo_vld_d, lo_vld_q;
  logic                     hi_vld_d, hi_vld_q;
  logic [15:0]              cnt_q;
  logic                     in_fire;

  // Reset gating keeps in_ready low while the flops are held clear.
  assign in_ready = ASYNCRESET_N & (~lo_vld_q | O0_ready) & (~hi_vld_q | O1_ready);
  assign in_fire  = in_valid & in_ready;

  assign lo_d = I0[SPLIT*ROW_W-1:0];

  for (genvar k = 0; k < HI_ROWS; k++) begin : g_hi
    localparam int SRC = (REVERSE_HI != 0) ? (ROWS-1-k) : (SPLIT+k);
    assign hi_d[k*ROW_W +: ROW_W] = I0[SRC*ROW_W +: ROW_W];
  end

  // A new frame wins over a same-edge drain, so valid stays high on back-to-back transfers.
  assign lo_vld_d = in_fire | (lo_vld_q & ~O0_ready);
  assign hi_vld_d = in_fire | (hi_vld_q & ~O1_ready);

  always_ff @(posedge CLK or negedge ASYNCRESET_N) begin
    if (!ASYNCRESET_N) begin
      lo_q     <= '0;
      hi_q     <= '0;
      tag_q    <= '0;
      flag_q   <= 1'b0;
      lo_vld_q <= 1'b0;
      hi_vld_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      lo_vld_q <= lo_vld_d;
      hi_vld_q <= hi_vld_d;
      if (in_fire) begin
        lo_q   <= lo_d;
        hi_q   <= hi_d;
        tag_q  <= I1__1;
        flag_q <= I1__0;
        cnt_q  <= cnt_q + 16'd1;
      end
    end
  end

  assign O0          = lo_q;
  assign O0_valid    = lo_vld_q;
  assign O1          = hi_q;
  assign O2__0       = tag_q;
  assign O2__1       = flag_q;
  assign O1_valid    = hi_vld_q;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_nd_array_split_buffer.sv
// Bench for nd_array_split_buffer: straight and reversed-hi instances driven in parallel,
// checked every negedge against a last-accepted-frame model plus literal spot values.
module tb_nd_array_split_buffer;
  localparam int W  = 8;
  localparam int C  = 16;
  localparam int R  = 12;
  localparam int S  = 4;
  localparam int T  = 3;
  localparam int FW = R*C*W;
  localparam int LW = S*C*W;
  localparam int HW = (R-S)*C*W;

  logic          CLK, ASYNCRESET_N;
  logic [FW-1:0] I0;
  logic          I1_0;
  logic [T-1:0]  I1_1;
  logic          in_valid, O0_ready, O1_ready;

  logic          in_ready_a, O0_valid_a, O1_valid_a, O2_1_a;
  logic [LW-1:0] O0_a;
  logic [HW-1:0] O1_a;
  logic [T-1:0]  O2_0_a;
  logic [15:0]   fc_a;
  logic          in_ready_b, O0_valid_b, O1_valid_b, O2_1_b;
  logic [LW-1:0] O0_b;
  logic [HW-1:0] O1_b;
  logic [T-1:0]  O2_0_b;
  logic [15:0]   fc_b;

  int checks = 0;
  int errors = 0;

  nd_array_split_buffer #(.WIDTH(W), .COLS(C), .ROWS(R), .SPLIT(S), .REVERSE_HI(0), .TAGW(T)) u_dut (
    .CLK(CLK), .ASYNCRESET_N(ASYNCRESET_N), .I0(I0), .I1__0(I1_0), .I1__1(I1_1),
    .in_valid(in_valid), .in_ready(in_ready_a), .O0(O0_a), .O0_valid(O0_valid_a), .O0_ready(O0_ready),
    .O1(O1_a), .O2__0(O2_0_a), .O2__1(O2_1_a), .O1_valid(O1_valid_a), .O1_ready(O1_ready),
    .frame_count(fc_a));

  nd_array_split_buffer #(.WIDTH(W), .COLS(C), .ROWS(R), .SPLIT(S), .REVERSE_HI(1), .TAGW(T)) u_rev (
    .CLK(CLK), .ASYNCRESET_N(ASYNCRESET_N), .I0(I0), .I1__0(I1_0), .I1__1(I1_1),
    .in_valid(in_valid), .in_ready(in_ready_b), .O0(O0_b), .O0_valid(O0_valid_b), .O0_ready(O0_ready),
    .O1(O1_b), .O2__0(O2_0_b), .O2__1(O2_1_b), .O1_valid(O1_valid_b), .O1_ready(O1_ready),
    .frame_count(fc_b));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: each channel shows the last accepted frame and a pending flag.
  logic [FW-1:0] m_frame = '0;
  logic          m_t0 = 1'b0;
  logic [T-1:0]  m_t1 = '0;
  logic          m_v0 = 1'b0, m_v1 = 1'b0;
  logic [15:0]   m_cnt = '0;
  wire           m_rdy = ASYNCRESET_N && (!m_v0 || O0_ready) && (!m_v1 || O1_ready);

  always @(posedge CLK or negedge ASYNCRESET_N) begin
    if (!ASYNCRESET_N) begin
      m_frame <= '0; m_t0 <= 1'b0; m_t1 <= '0; m_v0 <= 1'b0; m_v1 <= 1'b0; m_cnt <= '0;
    end else if (in_valid && m_rdy) begin
      m_frame <= I0; m_t0 <= I1_0; m_t1 <= I1_1; m_v0 <= 1'b1; m_v1 <= 1'b1; m_cnt <= m_cnt + 16'd1;
    end else begin
      if (O0_ready) m_v0 <= 1'b0;
      if (O1_ready) m_v1 <= 1'b0;
    end
  end

  function automatic logic [FW-1:0] exp_lo(input logic [FW-1:0] f);
    logic [FW-1:0] o = '0;
    for (int r = 0; r < S; r++) o[r*C*W +: C*W] = f[r*C*W +: C*W];
    return o;
  endfunction

  function automatic logic [FW-1:0] exp_hi(input logic [FW-1:0] f, input bit rev);
    logic [FW-1:0] o = '0;
    for (int k = 0; k < R-S; k++) begin
      int src = rev ? (R-1-k) : (S+k);
      o[k*C*W +: C*W] = f[src*C*W +: C*W];
    end
    return o;
  endfunction

  function automatic logic [FW-1:0] mkframe(input int base);
    logic [FW-1:0] f = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) f[(r*C+c)*W +: W] = 8'((r*16 + c + base) & 255);
    return f;
  endfunction

  function automatic logic [7:0] elem(input logic [FW-1:0] v, input int r, input int c);
    return v[(r*C+c)*W +: W];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      int idx = -1;
      errors++;
      for (int i = 0; i < R*C; i++)
        if (idx < 0 && act[i*W +: W] !== exp[i*W +: W]) idx = i;
      $display("FAIL %s: element %0d got %0h expected %0h at %0t", nm, idx,
               act[idx*W +: W], exp[idx*W +: W], $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("in_ready", 32'(in_ready_a), 32'(m_rdy));
    chk("in_ready_rev", 32'(in_ready_b), 32'(m_rdy));
    chk("O0_valid", 32'(O0_valid_a), 32'(m_v0));
    chk("O1_valid", 32'(O1_valid_a), 32'(m_v1));
    chk("O0_valid_rev", 32'(O0_valid_b), 32'(m_v0));
    chk("O1_valid_rev", 32'(O1_valid_b), 32'(m_v1));
    chk("frame_count", 32'(fc_a), 32'(m_cnt));
    chk("frame_count_rev", 32'(fc_b), 32'(m_cnt));
    chk_vec("O0", FW'(O0_a), exp_lo(m_frame));
    chk_vec("O0_rev", FW'(O0_b), exp_lo(m_frame));
    chk_vec("O1", FW'(O1_a), exp_hi(m_frame, 1'b0));
    chk_vec("O1_rev", FW'(O1_b), exp_hi(m_frame, 1'b1));
    chk("O2__0", 32'(O2_0_a), 32'(m_t1));
    chk("O2__1", 32'(O2_1_a), 32'(m_t0));
    chk("O2__0_rev", 32'(O2_0_b), 32'(m_t1));
    chk("O2__1_rev", 32'(O2_1_b), 32'(m_t0));
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic rst_pulse();
    #1 ASYNCRESET_N = 1'b0;
    #1;
    chk("rst_O0_valid", 32'(O0_valid_a), 32'd0);
    chk("rst_O1_valid", 32'(O1_valid_a), 32'd0);
    chk("rst_frame_count", 32'(fc_a), 32'd0);
    chk("rst_O0_elem", 32'(elem(FW'(O0_a), 0, 0)), 32'd0);
    chk("rst_in_ready", 32'(in_ready_a), 32'd0);
    #1 ASYNCRESET_N = 1'b1;
  endtask

  initial begin
    ASYNCRESET_N = 1'b0; I0 = '0; I1_0 = 1'b0; I1_1 = '0;
    in_valid = 1'b0; O0_ready = 1'b0; O1_ready = 1'b0;
    #1;
    chk("init_O0_valid", 32'(O0_valid_a), 32'd0);
    chk("init_frame_count", 32'(fc_a), 32'd0);
    chk("init_in_ready", 32'(in_ready_a), 32'd0);
    cycle(); cycle();
    ASYNCRESET_N = 1'b1;
    #1 chk("idle_in_ready", 32'(in_ready_a), 32'd1);

    // Basic split, straight and reversed hi slice
    I0 = mkframe(0); I1_0 = 1'b1; I1_1 = 3'd5; in_valid = 1'b1; O0_ready = 1'b1; O1_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("b_O0_r0c0", 32'(elem(FW'(O0_a), 0, 0)), 32'h00);
    chk("b_O0_r3c15", 32'(elem(FW'(O0_a), 3, 15)), 32'h3F);
    chk("b_O1_r0c0", 32'(elem(FW'(O1_a), 0, 0)), 32'h40);
    chk("b_O1_r7c15", 32'(elem(FW'(O1_a), 7, 15)), 32'hBF);
    chk("b_O2__0", 32'(O2_0_a), 32'd5);
    chk("b_O2__1", 32'(O2_1_a), 32'd1);
    chk("b_valids", 32'({O0_valid_a, O1_valid_a}), 32'd3);
    chk("b_frame_count", 32'(fc_a), 32'd1);
    chk("rev_O1_r0c0", 32'(elem(FW'(O1_b), 0, 0)), 32'hB0);
    chk("rev_O1_r7c0", 32'(elem(FW'(O1_b), 7, 0)), 32'h40);
    chk("rev_O0_r3c15", 32'(elem(FW'(O0_b), 3, 15)), 32'h3F);
    cycle();

    // Backpressure on hi channel only
    I0 = mkframe(32'h20); I1_0 = 1'b0; I1_1 = 3'd2; in_valid = 1'b1; O1_ready = 1'b0;
    cycle();
    I0 = mkframe(32'h50); I1_1 = 3'd6;
    #1 chk("bp_in_ready_1", 32'(in_ready_a), 32'd0);
    cycle();
    chk("bp_O0_valid", 32'(O0_valid_a), 32'd0);
    chk("bp_O1_valid", 32'(O1_valid_a), 32'd1);
    chk("bp_O1_hold", 32'(elem(FW'(O1_a), 0, 0)), 32'h60);
    chk("bp_in_ready_2", 32'(in_ready_a), 32'd0);
    cycle();
    chk("bp_in_ready_3", 32'(in_ready_a), 32'd0);
    chk("bp_frame_count", 32'(fc_a), 32'd2);
    O1_ready = 1'b1;
    #1 chk("bp_in_ready_rise", 32'(in_ready_a), 32'd1);
    cycle();
    in_valid = 1'b0;
    chk("bp_B_count", 32'(fc_a), 32'd3);
    chk("bp_B_O0", 32'(elem(FW'(O0_a), 0, 0)), 32'h50);
    chk("bp_B_O1", 32'(elem(FW'(O1_a), 0, 0)), 32'h90);
    chk("bp_B_O2__0", 32'(O2_0_a), 32'd6);
    cycle();

    // Async reset between edges with both channels holding a frame
    I0 = mkframe(32'h11); in_valid = 1'b1; O0_ready = 1'b0; O1_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk("pre_rst_valids", 32'({O0_valid_a, O1_valid_a}), 32'd3);
    rst_pulse();
    #1 chk("post_rst_in_ready", 32'(in_ready_a), 32'd1);
    I0 = mkframe(32'h22); in_valid = 1'b1; O0_ready = 1'b1; O1_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("post_rst_count", 32'(fc_a), 32'd1);
    chk("post_rst_O0", 32'(elem(FW'(O0_a), 0, 0)), 32'h22);
    chk("post_rst_O1", 32'(elem(FW'(O1_a), 0, 0)), 32'h62);
    cycle();
    chk("post_rst_drained", 32'({O0_valid_a, O1_valid_a}), 32'd0);

    // Full throughput from a clean reset
    rst_pulse();
    for (int i = 0; i < 20; i++) begin
      I0 = mkframe(i*7); in_valid = 1'b1;
      cycle();
    end
    chk("tp_frame_count", 32'(fc_a), 32'd20);
    chk("tp_last_O0", 32'(elem(FW'(O0_a), 0, 0)), 32'd133);
    chk("tp_last_O1", 32'(elem(FW'(O1_a), 0, 0)), 32'd197);

    // Counter wrap
    repeat (65535-20) cycle();
    chk("wrap_ffff", 32'(fc_a), 32'hFFFF);
    cycle();
    chk("wrap_zero", 32'(fc_a), 32'h0000);
    in_valid = 1'b0;
    cycle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
